// File: rtl/cachemem_pkg.sv
// cachemem_pkg -- shared types and helpers for the byte-enabled cache memory.
//   state_t     : sweep FSM states (CLEAR, IDLE)
//   bewidth()   : byte-enable width rule, BEWIDTH = DWIDTH/8
//   byte_merge(): merge a new word into an old word under byte enables
// byte_merge works on a fixed maximum width; callers zero-extend their
// words into word_t and take back the low DWIDTH bits.
package cachemem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int MAX_DWIDTH  = 256;
  localparam int MAX_BEWIDTH = MAX_DWIDTH / 8;

  typedef logic [MAX_DWIDTH-1:0]  word_t;
  typedef logic [MAX_BEWIDTH-1:0] be_t;

  function automatic int bewidth(input int dwidth);
    return dwidth / 8;
  endfunction

  function automatic word_t byte_merge(input word_t old_w, input word_t new_w, input be_t be);
    word_t merged;
    for (int k = 0; k < MAX_BEWIDTH; k++) begin
      merged[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/cachemem_be_ram.sv
// cachemem_be_ram -- byte-enabled single-port RAM, registered (1-cycle) read.
// Written as a behavioural array in the read-modify-write form that
// synthesis maps onto a byte-write block RAM.
// Ports:
//   clk_i   clock
//   we_i    write strobe (bytes selected by be_i)
//   re_i    read strobe; dout_o updates one edge later
//   be_i    byte enables, bit k covers bits 8k+7:8k
//   addr_i  word address
//   din_i   write data
//   dout_o  read data, holds between reads
module cachemem_be_ram
  import cachemem_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DWIDTH/8-1:0]   be_i,
  input  logic [AWIDTH-1:0]     addr_i,
  input  logic [DWIDTH-1:0]     din_i,
  output logic [DWIDTH-1:0]     dout_o
);

  localparam int DEPTH   = 2**AWIDTH;
  localparam int BEWIDTH = bewidth(DWIDTH);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_dout;

  word_t w_old;
  word_t w_new;
  word_t w_merged;
  be_t   w_be;
  logic  w_unused_merge;

  // NOTE: every variable gets a default at the top of always_comb, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_old = '0;
    w_new = '0;
    w_be  = '0;
    w_old[DWIDTH-1:0]  = r_mem[addr_i];
    w_new[DWIDTH-1:0]  = din_i;
    w_be[BEWIDTH-1:0]  = be_i;
    w_merged = byte_merge(w_old, w_new, w_be);
  end

  // Bits above DWIDTH are always zero-extension padding.
  assign w_unused_merge = ^w_merged;

  // NOTE: the array and its read register have no reset; RAM macros cannot
  // be reset, and contents are defined by the clear sweep or by writes.
  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[addr_i] <= w_merged[DWIDTH-1:0];
    if (re_i) r_dout <= r_mem[addr_i];
  end

  assign dout_o = r_dout;

endmodule

// File: rtl/cachemem_be.sv
// cachemem_be -- pipelined, byte-enabled single-port cache data memory.
// Build option: define CACHEMEM_CLEAR_EN to build the clear-sweep FSM that
// fills every word with INITVAL after reset and on clear_i.
// Ports:
//   clk_i, rst_n_i  clock, synchronous active-low reset
//   req_i, we_i     request, 1 = write / 0 = read
//   be_i            write byte enables
//   address_i, in_i word address, write data
//   ready_o         request accepted this cycle when req_i=1
//   clear_i         start a clear sweep (honoured when ready_o=1)
//   busy_o          clear sweep in progress
//   valid_o, out_o  read strobe and read data (out_o holds otherwise)
module cachemem_be
  import cachemem_pkg::*;
#(
  parameter int                AWIDTH  = 10,
  parameter int                DWIDTH  = 32,
  parameter int                OUTREG  = 1,
  parameter logic [DWIDTH-1:0] INITVAL = '0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [DWIDTH/8-1:0] be_i,
  input  logic [AWIDTH-1:0]   address_i,
  input  logic [DWIDTH-1:0]   in_i,
  output logic                ready_o,
  input  logic                clear_i,
  output logic                busy_o,
  output logic                valid_o,
  output logic [DWIDTH-1:0]   out_o
);

  localparam int BEWIDTH = bewidth(DWIDTH);

  logic                w_ready;
  logic                w_accept;
  logic                w_rd;
  logic                w_user_we;
  logic                w_ram_we;
  logic [BEWIDTH-1:0]  w_ram_be;
  logic [AWIDTH-1:0]   w_ram_addr;
  logic [DWIDTH-1:0]   w_ram_din;
  logic [DWIDTH-1:0]   w_ram_dout;

  assign w_accept  = req_i && w_ready;
  assign w_rd      = w_accept && !we_i;
  assign w_user_we = w_accept && we_i;

`ifdef CACHEMEM_CLEAR_EN
  state_t            r_state, w_state_nx;
  logic [AWIDTH-1:0] r_cnt, w_cnt_nx;
  logic              r_ready, r_busy;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_ready <= (w_state_nx == IDLE);
      r_busy  <= (w_state_nx == CLEAR);
    end
  end

  // The sweep owns the RAM port while in CLEAR; ready_o is low then, so no
  // user access can collide with it. Writes are gated during reset so an
  // abandoned sweep leaves no stray write behind.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_ram_we   = rst_n_i && w_user_we;
    w_ram_be   = be_i;
    w_ram_addr = address_i;
    w_ram_din  = in_i;
    case (r_state)
      CLEAR: begin
        w_ram_we   = rst_n_i;
        w_ram_be   = {BEWIDTH{1'b1}};
        w_ram_addr = r_cnt;
        w_ram_din  = INITVAL;
        w_cnt_nx   = r_cnt + 1'b1;
        if (r_cnt == {AWIDTH{1'b1}}) w_state_nx = IDLE;
      end
      IDLE: begin
        // A request accepted in this cycle still executes; the sweep
        // begins on the following cycle.
        if (clear_i) begin
          w_state_nx = CLEAR;
          w_cnt_nx   = '0;
        end
      end
      default: w_state_nx = CLEAR;
    endcase
  end

  assign w_ready = r_ready;
  assign busy_o  = r_busy;
`else
  logic w_unused;

  assign w_ready    = 1'b1;
  assign busy_o     = 1'b0;
  assign w_ram_we   = rst_n_i && w_user_we;
  assign w_ram_be   = be_i;
  assign w_ram_addr = address_i;
  assign w_ram_din  = in_i;
  assign w_unused   = ^{clear_i, INITVAL};
`endif

  assign ready_o = w_ready;

  cachemem_be_ram #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (w_ram_we),
    .re_i   (w_rd),
    .be_i   (w_ram_be),
    .addr_i (w_ram_addr),
    .din_i  (w_ram_din),
    .dout_o (w_ram_dout)
  );

  // Read pipeline: RAM read register, optional extra stage, output register.
  logic              r_v1;
  logic              w_pipe_v;
  logic [DWIDTH-1:0] w_pipe_d;
  logic              r_valid;
  logic [DWIDTH-1:0] r_out;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_v1 <= 1'b0;
    else          r_v1 <= w_rd;
  end

  generate
    if (OUTREG != 0) begin : g_outreg
      logic              r_v2;
      logic [DWIDTH-1:0] r_d2;
      always_ff @(posedge clk_i) begin
        if (!rst_n_i) r_v2 <= 1'b0;
        else          r_v2 <= r_v1;
        if (r_v1) r_d2 <= w_ram_dout;
      end
      assign w_pipe_v = r_v2;
      assign w_pipe_d = r_d2;
    end else begin : g_no_outreg
      assign w_pipe_v = r_v1;
      assign w_pipe_d = w_ram_dout;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      r_out   <= '0;
    end else begin
      r_valid <= w_pipe_v;
      if (w_pipe_v) r_out <= w_pipe_d;
    end
  end

  assign valid_o = r_valid;
  assign out_o   = r_out;

endmodule

// File: tb/tb_cachemem_be.sv
// tb_cachemem_be -- self-checking bench for cachemem_be (AWIDTH=4, OUTREG=1).
// A reference model tracks memory contents, sweep cycles remaining and the
// expected read stream; every cycle the DUT handshake and read outputs are
// compared against it.
module tb_cachemem_be;

  localparam int          AW      = 4;
  localparam int          DW      = 32;
  localparam int          BW      = DW / 8;
  localparam int          DEPTH   = 2**AW;
  localparam int          OUTREG  = 1;
  localparam logic [31:0] INITVAL = 32'hA5C3_3C5A;
`ifdef CACHEMEM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  localparam int SWEEP = CLR ? DEPTH : 0;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          req_i, we_i, clear_i;
  logic [BW-1:0] be_i;
  logic [AW-1:0] address_i;
  logic [DW-1:0] in_i;
  logic          ready_o, busy_o, valid_o;
  logic [DW-1:0] out_o;

  cachemem_be #(
    .AWIDTH (AW),
    .DWIDTH (DW),
    .OUTREG (OUTREG),
    .INITVAL(INITVAL)
  ) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .req_i    (req_i),
    .we_i     (we_i),
    .be_i     (be_i),
    .address_i(address_i),
    .in_i     (in_i),
    .ready_o  (ready_o),
    .clear_i  (clear_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .out_o    (out_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          sweep_left = 0;
  int          run = 0;
  int          max_run = 0;
  int          n;
  logic [31:0] exp_mem [DEPTH];
  logic [31:0] exp_q [$];
  int          due_q [$];
  logic [31:0] last_out = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic [BW-1:0] be,
                       input logic [AW-1:0] addr, input logic [DW-1:0] din, input logic clr);
    req_i = req; we_i = we; be_i = be; address_i = addr; in_i = din; clear_i = clr;
  endtask

  // One clock: apply the model at the edge, then compare at the negedge.
  task automatic tick();
    bit idle;
    bit acc;
    idle = (sweep_left == 0);
    acc  = req_i && idle;
    @(posedge clk_i);
    cyc++;
    if (!rst_n_i) begin
      exp_q.delete();
      due_q.delete();
      last_out   = '0;
      sweep_left = SWEEP;
      if (CLR) for (int i = 0; i < DEPTH; i++) exp_mem[i] = INITVAL;
    end else begin
      if (!idle) sweep_left--;
      if (acc && we_i) begin
        for (int k = 0; k < BW; k++)
          if (be_i[k]) exp_mem[address_i][8*k +: 8] = in_i[8*k +: 8];
      end else if (acc) begin
        exp_q.push_back(exp_mem[address_i]);
        due_q.push_back(cyc + 1 + OUTREG);
      end
      if (CLR && idle && clear_i) begin
        sweep_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = INITVAL;
      end
    end
    @(negedge clk_i);
    check("ready", ready_o, sweep_left == 0);
    check("busy", busy_o, sweep_left != 0);
    if (valid_o) begin
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        last_out = exp_q.pop_front();
        check("rd_data", out_o, last_out);
        check("rd_latency", cyc, due_q.pop_front());
      end
    end else begin
      run = 0;
      check("out_hold", out_o, last_out);
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        check("missing_valid", 0, 1);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
  endtask

  task automatic idle_ticks(input int k);
    drive(0, 0, '0, '0, '0, 0);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic wait_ready(output int cnt);
    drive(0, 0, '0, '0, '0, 0);
    cnt = 0;
    while (!ready_o && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst_n_i = 1'b0;
    drive(0, 0, '0, '0, '0, 0);
    tick();
    check("rst_busy", busy_o, CLR);
    check("rst_valid", valid_o, 0);
    check("rst_out", out_o, 0);
    rst_n_i = 1'b1;
    wait_ready(n);
    check("sweep_len", n, SWEEP);

`ifndef CACHEMEM_CLEAR_EN
    for (int a = 0; a < DEPTH; a++) begin
      drive(1, 1, '1, a[AW-1:0], $urandom, 0);
      tick();
    end
`endif

    // Read back every word, one request per cycle.
    for (int a = 0; a < DEPTH; a++) begin
      drive(1, 0, '0, a[AW-1:0], '0, 0);
      tick();
    end
    idle_ticks(4);

    // Full write, then a single-byte write, then read the merged word.
    drive(1, 1, 4'b1111, 4'd5, 32'hDEADBEEF, 0); tick();
    drive(1, 1, 4'b0010, 4'd5, 32'h00001200, 0); tick();
    drive(1, 0, '0, 4'd5, '0, 0); tick();
    idle_ticks(4);
    check("merge_out", out_o, 32'hDEAD12EF);

    // be=0 write must leave the word untouched.
    drive(1, 1, 4'b0000, 4'd5, 32'h11111111, 0); tick();
    drive(1, 0, '0, 4'd5, '0, 0); tick();
    idle_ticks(4);
    check("be0_noop", out_o, 32'hDEAD12EF);

    // Back-to-back reads of 0..7.
    for (int a = 0; a < 8; a++) begin
      drive(1, 1, '1, a[AW-1:0], $urandom, 0);
      tick();
    end
    max_run = 0;
    for (int a = 0; a < 8; a++) begin
      drive(1, 0, '0, a[AW-1:0], '0, 0);
      tick();
    end
    idle_ticks(4);
    check("b2b_run", max_run, 8);

    // Clear together with a read: read sees old data, sweep follows.
    drive(1, 1, '1, 4'd3, 32'h55, 0); tick();
    drive(1, 0, '0, 4'd3, '0, 1); tick();
    wait_ready(n);
    check("clear_sweep_len", n, SWEEP);
    drive(1, 0, '0, 4'd3, '0, 0); tick();
    idle_ticks(4);
    check("post_clear_rd3", out_o, CLR ? INITVAL : 32'h55);

    // Read in flight at reset is discarded; reset at sweep address 9.
    drive(1, 0, '0, 4'd1, '0, 0); tick();
    drive(0, 0, '0, '0, '0, 0);
    rst_n_i = 1'b0; tick();
    rst_n_i = 1'b1;
    idle_ticks(9);
    rst_n_i = 1'b0; tick();
    rst_n_i = 1'b1;
    wait_ready(n);
    check("restart_sweep_len", n, SWEEP);
    idle_ticks(3);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, BW'($urandom),
            AW'($urandom), $urandom, $urandom_range(0, 60) == 0);
      tick();
    end
    idle_ticks(6);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
